rffp_conv_sched: RTL and testbench

Round-robin scheduler that shares one RFFP→FP conversion datapath between NUM_REQ requesters (tensor-core lanes feeding FP accumulate). Each requester offers a 15-bit RFFP word over valid/ready. The block grants one word per cycle, runs it through a single converter instance between two register stages, and returns the 16-bit FP result tagged with the requester ID. Full throughput is one word per cycle, with backpressure from the consumer.

---
 rtl/rffp_conv_sched_if.sv | 28 ++
 rtl/rffp_conv_sched.sv | 127 ++++++++++++
 tb/tb_rffp_conv_sched.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rffp_conv_sched_if.sv
// Requester/consumer bundle for the shared RFFP->FP conversion scheduler.
// The slave side is the scheduler and the master side is the surrounding lanes.
interface rffp_conv_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int IN_W    = 15,
  parameter int OUT_W   = 16,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]      in_valid;
  logic [NUM_REQ*IN_W-1:0] in_data;
  logic [NUM_REQ-1:0]      in_ready;
  logic                    out_valid;
  logic [OUT_W-1:0]        out_data;
  logic [ID_W-1:0]         out_id;
  logic                    out_ready;
  logic                    busy;
  logic [15:0]             done_count;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_id, busy, done_count
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_id, busy, done_count
  );
endinterface

// File: rtl/rffp_conv_sched.sv
// Round-robin scheduler sharing one RFFP->FP converter among NUM_REQ requesters.
// Two register stages: S1 holds the granted word, S2 holds the converted result.
module rffp_conv_sched #(
  parameter int NUM_REQ        = 4,
  parameter int EXP_WIDTH      = 8,
  parameter int MAN_WIDTH      = 7,
  parameter int RFFP_EXP       = 6,
  parameter int RFFP_MAN_WIDTH = 8,
  parameter int ID_W           = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  rffp_conv_sched_if.slave   bus
);
  localparam int IN_W    = RFFP_EXP + RFFP_MAN_WIDTH + 1;
  localparam int OUT_W   = EXP_WIDTH + MAN_WIDTH + 1;
  localparam int LZ_W    = $clog2(RFFP_MAN_WIDTH + 1);
  localparam int EXP_OFS = 76;

  // Exponent is rebased by the leading-zero count; the mantissa field is passed through unshifted.
  function automatic logic [OUT_W-1:0] rffp_to_fp(input logic [IN_W-1:0] w);
    logic                      sgn;
    logic [RFFP_EXP-1:0]       e;
    logic [RFFP_MAN_WIDTH-1:0] m;
    logic [LZ_W-1:0]           lz;
    logic [EXP_WIDTH-1:0]      ex;
    logic                      found;
    {sgn, e, m} = w;
    lz    = '0;
    found = 1'b0;
    for (int i = RFFP_MAN_WIDTH - 1; i >= 0; i--) begin
      if (!found) begin
        if (m[i]) found = 1'b1;
        else      lz    = lz + LZ_W'(1);
      end
    end
    if (m == '0) lz = '0;
    ex = EXP_WIDTH'(e) - EXP_WIDTH'(lz) + EXP_WIDTH'(EXP_OFS);
    if (e == '0 || m == '0) ex = '0;
    return {sgn, ex, m[MAN_WIDTH-1:0]};
  endfunction

  logic               s1_valid;
  logic [IN_W-1:0]    s1_data;
  logic [ID_W-1:0]    s1_id;
  logic               s2_valid;
  logic [OUT_W-1:0]   s2_data;
  logic [ID_W-1:0]    s2_id;
  logic [ID_W-1:0]    rr_ptr;
  logic [15:0]        done_cnt;

  logic               s2_free;
  logic               s1_free;
  logic               gnt_found;
  logic [ID_W-1:0]    gnt_idx;
  logic [ID_W-1:0]    cand;
  logic [ID_W-1:0]    rr_next;
  logic [NUM_REQ-1:0] in_ready_c;
  logic               accept;

  assign s2_free = !s2_valid || bus.out_ready;
  assign s1_free = !s1_valid || s2_free;

  // Search starts at rr_ptr and wraps, so the last winner becomes lowest priority.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!gnt_found && bus.in_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_comb begin
    in_ready_c = '0;
    if (rst_n && gnt_found) in_ready_c[gnt_idx] = s1_free;
  end

  assign accept  = gnt_found && s1_free;
  assign rr_next = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);

  // S1 / S2 control, rotation pointer and handshake counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_id    <= '0;
      rr_ptr   <= '0;
      done_cnt <= '0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        rr_ptr   <= rr_next;
      end else if (s2_free) begin
        s1_valid <= 1'b0;
      end
      if (s2_free) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_data <= rffp_to_fp(s1_data);
          s2_id   <= s1_id;
        end
      end
      if (s2_valid && bus.out_ready) done_cnt <= done_cnt + 16'd1;
    end
  end

  // S1 payload
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_data <= bus.in_data[gnt_idx*IN_W +: IN_W];
      s1_id   <= gnt_idx;
    end
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.out_valid  = s2_valid;
  assign bus.out_data   = s2_data;
  assign bus.out_id     = s2_id;
  assign bus.busy       = s1_valid | s2_valid;
  assign bus.done_count = done_cnt;
endmodule

// File: tb/tb_rffp_conv_sched.sv
// Bench for rffp_conv_sched: conversion vectors, round-robin order, backpressure,
// counter wrap and mid-stream reset, all against an in-order queue reference model.
module tb_rffp_conv_sched;
  localparam int N     = 4;
  localparam int IN_W  = 15;
  localparam int OUT_W = 16;
  localparam int ID_W  = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  rffp_conv_sched_if #(.NUM_REQ(N), .IN_W(IN_W), .OUT_W(OUT_W), .ID_W(ID_W)) bus ();
  rffp_conv_sched #(.NUM_REQ(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct { int id; logic [14:0] d; int unsigned acc; } item_t;
  typedef struct { logic [14:0] word; logic [15:0] exp_fp; int id; } vec_t;

  item_t       q[$];
  int          id_log[$];
  vec_t        vecs[6];
  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned cyc = 0;
  int unsigned delivered = 0;
  int          mptr = 0;
  int          pops = 0;
  int          dut_acc = 0;
  int          refill_pct = 0;
  bit          rand_ordy = 0;
  logic        ordy = 1'b1;
  bit          pend_v[N];
  logic [14:0] pend_d[N];
  logic [15:0] last_out_data;
  int          last_out_id;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference conversion from the format rules, using integer arithmetic
  function automatic logic [15:0] model_conv(input logic [14:0] w);
    int m, e, lz, t, ex;
    logic [7:0] exb;
    logic [6:0] man;
    m = int'(w[7:0]);
    e = int'(w[13:8]);
    man = w[6:0];
    lz = 0;
    if (m != 0) begin
      t = m; lz = 8;
      while (t != 0) begin t = t / 2; lz--; end
    end
    ex = 0;
    if (e != 0 && m != 0) ex = (e - lz + 76) % 256;
    exb = ex[7:0];
    return {w[14], exb, man};
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.in_valid[i]               = pend_v[i];
      bus.in_data[i*IN_W +: IN_W]   = pend_d[i];
    end
    bus.out_ready = ordy;
  endtask

  // One clock: check DUT against model before the edge, advance model after it.
  task automatic tick();
    int g;
    logic [N-1:0] er;
    bit s1f, ov;
    @(negedge clk);
    g = -1;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (mptr + k) % N;
      if (g < 0 && pend_v[idx]) g = idx;
    end
    s1f = (q.size() < 2) || (ordy == 1'b1);
    er = '0;
    if (g >= 0 && s1f) er[g] = 1'b1;
    ov = (q.size() > 0) && (cyc - q[0].acc >= 1);
    check("in_ready", 32'(bus.in_ready), 32'(er));
    check("out_valid", 32'(bus.out_valid), 32'(ov));
    check("busy", 32'(bus.busy), 32'(q.size() > 0));
    check("done_count", 32'(bus.done_count), delivered & 32'hFFFF);
    if (ov) begin
      check("out_data", 32'(bus.out_data), 32'(model_conv(q[0].d)));
      check("out_id", 32'(bus.out_id), q[0].id);
      last_out_data = bus.out_data;
      last_out_id   = int'(bus.out_id);
      if (ordy) id_log.push_back(int'(bus.out_id));
    end
    if ((bus.in_valid & bus.in_ready) != '0) dut_acc++;
    @(posedge clk); #1;
    cyc++;
    if (ov && ordy) begin
      void'(q.pop_front());
      delivered++;
      pops++;
    end
    if (g >= 0 && s1f) begin
      item_t it;
      it.id = g; it.d = pend_d[g]; it.acc = cyc;
      q.push_back(it);
      mptr = (g + 1) % N;
      pend_v[g] = 0;
    end
    for (int i = 0; i < N; i++)
      if (!pend_v[i] && refill_pct > 0 && $urandom_range(99) < refill_pct) begin
        pend_v[i] = 1;
        pend_d[i] = 15'($urandom);
      end
    if (rand_ordy) ordy = ($urandom_range(99) < 70);
    drive();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done_count", 32'(bus.done_count), 0);
    check("rst_in_ready", 32'(bus.in_ready), 0);
    check("rst_out_data", 32'(bus.out_data), 0);
    check("rst_out_id", 32'(bus.out_id), 0);
    for (int i = 0; i < N; i++) pend_v[i] = 0;
    refill_pct = 0; rand_ordy = 0; ordy = 1'b1;
    drive();
    q.delete(); mptr = 0; delivered = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic all_valid();
    for (int i = 0; i < N; i++) begin pend_v[i] = 1; pend_d[i] = 15'($urandom); end
    drive();
  endtask

  initial begin
    vecs[0] = '{15'h2080, 16'h3600, 2};
    vecs[1] = '{15'h4A01, 16'hA781, 0};
    vecs[2] = '{15'h00C3, 16'h0043, 1};
    vecs[3] = '{15'h1500, 16'h0000, 3};
    vecs[4] = '{15'h3FFF, 16'h45FF, 1};
    vecs[5] = '{15'h4101, 16'hA301, 3};
    for (int i = 0; i < N; i++) begin pend_v[i] = 0; pend_d[i] = '0; end
    drive();
    #2;
    apply_reset();

    // Conversion vectors, one word at a time
    for (int v = 0; v < 6; v++) begin
      int t, p0;
      pend_v[vecs[v].id] = 1;
      pend_d[vecs[v].id] = vecs[v].word;
      drive();
      p0 = pops; t = 0;
      while (pops == p0 && t < 8) begin tick(); t++; end
      check("vec_delivered", 32'(pops - p0), 1);
      check("vec_fp", 32'(last_out_data), 32'(vecs[v].exp_fp));
      check("vec_id", 32'(last_out_id), vecs[v].id);
      if (v == 0) begin
        check("latency_ticks", 32'(t), 3);
        check("done_count_single", 32'(bus.done_count), 1);
      end
    end

    // Round-robin with everyone valid and no backpressure
    apply_reset();
    refill_pct = 100;
    all_valid();
    #1 check("first_grant", 32'(bus.in_ready), 32'h1);
    id_log.delete();
    repeat (14) tick();
    check("rr_count", 32'(id_log.size()), 12);
    for (int k = 0; k < 8; k++) check("rr_order", 32'(id_log[k]), k % 4);
    check("rr_done_count", 32'(bus.done_count), 12);

    // Backpressure: only two words fit, then drain in order
    apply_reset();
    ordy = 1'b0;
    refill_pct = 100;
    all_valid();
    begin
      int a0;
      a0 = dut_acc;
      repeat (5) tick();
      #1;
      check("bp_accepts", 32'(dut_acc - a0), 2);
      check("bp_ready_zero", 32'(bus.in_ready), 0);
    end
    ordy = 1'b1;
    drive();
    repeat (6) tick();
    refill_pct = 0;
    for (int i = 0; i < N; i++) pend_v[i] = 0;
    drive();
    repeat (4) tick();
    check("bp_drained", 32'(bus.busy), 0);

    // Randomized traffic with random backpressure
    apply_reset();
    refill_pct = 40;
    rand_ordy  = 1;
    repeat (1500) tick();
    rand_ordy = 0; ordy = 1'b1; refill_pct = 0;
    for (int i = 0; i < N; i++) pend_v[i] = 0;
    drive();
    repeat (4) tick();

    // Reset while both stages are full
    ordy = 1'b0;
    refill_pct = 100;
    all_valid();
    repeat (3) tick();
    check("pre_rst_busy", 32'(bus.busy), 1);
    #2;
    apply_reset();
    pend_v[1] = 1; pend_d[1] = 15'h2080;
    pend_v[3] = 1; pend_d[3] = 15'h4A01;
    drive();
    #1 check("post_rst_grant", 32'(bus.in_ready), 32'h2);
    repeat (6) tick();

    // Counter wrap after 65536 handshakes
    apply_reset();
    refill_pct = 100;
    all_valid();
    begin
      int guard;
      guard = 0;
      while (delivered < 65536 && guard < 70000) begin tick(); guard++; end
    end
    check("wrap_reached", delivered, 65536);
    check("wrap_done_count", 32'(bus.done_count), 0);
    check("wrap_out_valid", 32'(bus.out_valid), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
